// File: rtl/reg_file_cmd_ctrl.sv
// reg_file_cmd_ctrl
//   Decodes a byte stream from a UART receiver into register file accesses.
//   0xAA <addr> <data> writes one register. 0xBB <addr> reads one register
//   and forwards the byte to the TX FIFO. 0xCC <d0> <d1> writes d0 to
//   address 0 and d1 to address 1.
//
//   Optional feature (macro RD_TIMEOUT_EN): the read wait is bounded. If
//   RdData_Valid is not seen within 15 cycles, Err pulses for one cycle, no
//   byte is sent, and the FSM returns to IDLE. With the macro undefined the
//   read wait is unbounded and Err is tied to 0.
//
// Ports
//   CLK, RST              clock; asynchronous active-high reset
//   RX_Data, RX_Valid     received byte and its single-cycle strobe
//   Address, WrEn, RdEn   register file address and access strobes
//   WrData                register file write data
//   RdData, RdData_Valid  register file read data and its qualifier
//   TX_Data, TX_Valid     byte and single-cycle write strobe to the TX FIFO
//   FIFO_Full             TX FIFO full flag; holds off TX_Valid
//   Busy                  high whenever the FSM is not in IDLE
//   Err                   single-cycle read-timeout pulse
module reg_file_cmd_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_Data,
    input  logic                  RX_Valid,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    output logic [DATA_WIDTH-1:0] TX_Data,
    output logic                  TX_Valid,
    input  logic                  FIFO_Full,
    output logic                  Busy,
    output logic                  Err
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_OP = DATA_WIDTH'(8'hCC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_TX_SEND,
        S_OP_A,
        S_OP_B
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  busy_q, busy_d;

`ifdef RD_TIMEOUT_EN
    // The wait gives up once the counter has covered 15 RD_WAIT cycles.
    localparam int unsigned    TMO_W    = 4;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(14);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        lat_addr_d = lat_addr_q;
        wr_data_d  = wr_data_q;
        tx_data_d  = tx_data_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        tx_valid_d = 1'b0;
`ifdef RD_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (RX_Valid) begin
                    if (RX_Data == CMD_WR) begin
                        state_d = S_WR_ADDR;
                    end else if (RX_Data == CMD_RD) begin
                        state_d = S_RD_ADDR;
                    end else if (RX_Data == CMD_OP) begin
                        state_d = S_OP_A;
                    end
                end
            end

            S_WR_ADDR: begin
                if (RX_Valid) begin
                    lat_addr_d = RX_Data[ADDR_WIDTH-1:0];
                    state_d    = S_WR_DATA;
                end
            end

            S_WR_DATA: begin
                if (RX_Valid) begin
                    wr_en_d   = 1'b1;
                    addr_d    = lat_addr_q;
                    wr_data_d = RX_Data;
                    state_d   = S_IDLE;
                end
            end

            S_OP_A: begin
                if (RX_Valid) begin
                    wr_en_d   = 1'b1;
                    addr_d    = '0;
                    wr_data_d = RX_Data;
                    state_d   = S_OP_B;
                end
            end

            S_OP_B: begin
                if (RX_Valid) begin
                    wr_en_d   = 1'b1;
                    addr_d    = ADDR_WIDTH'(1);
                    wr_data_d = RX_Data;
                    state_d   = S_IDLE;
                end
            end

            S_RD_ADDR: begin
                if (RX_Valid) begin
                    rd_en_d = 1'b1;
                    addr_d  = RX_Data[ADDR_WIDTH-1:0];
                    state_d = S_RD_WAIT;
`ifdef RD_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end

            // RX bytes arriving here and in TX_SEND are dropped.
            S_RD_WAIT: begin
                if (RdData_Valid) begin
                    tx_data_d = RdData;
                    state_d   = S_TX_SEND;
`ifdef RD_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
                end
            end

            S_TX_SEND: begin
                if (!FIFO_Full) begin
                    tx_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered from the next state so Busy lines up with state_q.
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            lat_addr_q <= '0;
            wr_data_q  <= '0;
            tx_data_q  <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            lat_addr_q <= lat_addr_d;
            wr_data_q  <= wr_data_d;
            tx_data_q  <= tx_data_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
        end
    end

`ifdef RD_TIMEOUT_EN
    // Read-timeout counter and error pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

    assign Address  = addr_q;
    assign WrEn     = wr_en_q;
    assign RdEn     = rd_en_q;
    assign WrData   = wr_data_q;
    assign TX_Data  = tx_data_q;
    assign TX_Valid = tx_valid_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// tb_reg_file_cmd_ctrl
//   Directed bench for reg_file_cmd_ctrl: a table of byte sequences with
//   hand-computed strobe counts and values, plus hand-written sequences for
//   latency, backpressure, dropped bytes, mid-command reset and read timeout.
//   A small register-file model answers reads in the RdEn cycle.
module tb_reg_file_cmd_ctrl;

    logic       CLK;
    logic       RST;
    logic [7:0] RX_Data;
    logic       RX_Valid;
    logic [3:0] Address;
    logic       WrEn;
    logic       RdEn;
    logic [7:0] WrData;
    logic [7:0] RdData;
    logic       RdData_Valid;
    logic [7:0] TX_Data;
    logic       TX_Valid;
    logic       FIFO_Full;
    logic       Busy;
    logic       Err;

    reg_file_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_Data      (RX_Data),
        .RX_Valid     (RX_Valid),
        .Address      (Address),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .WrData       (WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .TX_Data      (TX_Data),
        .TX_Valid     (TX_Valid),
        .FIFO_Full    (FIFO_Full),
        .Busy         (Busy),
        .Err          (Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file model.
    logic [7:0] mem [16];
    logic       rd_resp_en;
    always @(posedge CLK) if (WrEn) mem[Address] <= WrData;
    assign RdData       = mem[Address];
    assign RdData_Valid = RdEn & rd_resp_en;

    // Strobe monitor.
    int         wr_cnt, rd_cnt, tx_cnt, err_cnt, both_cnt;
    logic [3:0] last_wa, last_ra;
    logic [7:0] last_wd, last_tx;
    initial begin
        wr_cnt = 0; rd_cnt = 0; tx_cnt = 0; err_cnt = 0; both_cnt = 0;
        last_wa = '0; last_ra = '0; last_wd = '0; last_tx = '0;
    end
    always @(negedge CLK) begin
        if (WrEn) begin wr_cnt++; last_wa = Address; last_wd = WrData; end
        if (RdEn) begin rd_cnt++; last_ra = Address; end
        if (TX_Valid) begin tx_cnt++; last_tx = TX_Data; end
        if (Err) err_cnt++;
        if (WrEn && RdEn) both_cnt++;
    end

    int tests, fails;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // Drives one byte for one cycle; returns at the negedge of the next cycle.
    task automatic send(input logic [7:0] b);
        RX_Data  = b;
        RX_Valid = 1'b1;
        @(negedge CLK);
        RX_Valid = 1'b0;
        RX_Data  = 8'h00;
    endtask

    typedef struct {
        string      name;
        int         n;
        logic [7:0] b0, b1, b2;
        int         exp_wr, exp_rd, exp_tx;
        logic [3:0] exp_wa;
        logic [7:0] exp_wd;
        logic [3:0] exp_ra;
        logic [7:0] exp_tx_d;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int w0, r0, t0, e0, hi_cnt;

        tests = 0; fails = 0;
        RST = 1'b1; RX_Data = 8'h00; RX_Valid = 1'b0; FIFO_Full = 1'b0;
        rd_resp_en = 1'b1;

        vecs[0] = '{"write",      3, 8'hAA, 8'h05, 8'h3C, 1, 0, 0, 4'h5, 8'h3C, 4'h0, 8'h00};
        vecs[1] = '{"read5",      2, 8'hBB, 8'h05, 8'h00, 0, 1, 1, 4'h0, 8'h00, 4'h5, 8'h3C};
        vecs[2] = '{"operands",   3, 8'hCC, 8'h12, 8'h34, 2, 0, 0, 4'h1, 8'h34, 4'h0, 8'h00};
        vecs[3] = '{"read0",      2, 8'hBB, 8'h00, 8'h00, 0, 1, 1, 4'h0, 8'h00, 4'h0, 8'h12};
        vecs[4] = '{"read1",      2, 8'hBB, 8'h01, 8'h00, 0, 1, 1, 4'h0, 8'h00, 4'h1, 8'h34};
        vecs[5] = '{"junk",       1, 8'h55, 8'h00, 8'h00, 0, 0, 0, 4'h0, 8'h00, 4'h0, 8'h00};
        vecs[6] = '{"cmd_as_data",3, 8'hAA, 8'hBB, 8'hCC, 1, 0, 0, 4'hB, 8'hCC, 4'h0, 8'h00};
        vecs[7] = '{"readB",      2, 8'hBB, 8'h0B, 8'h00, 0, 1, 1, 4'h0, 8'h00, 4'hB, 8'hCC};
        vecs[8] = '{"addr_trunc", 3, 8'hAA, 8'h1F, 8'h77, 1, 0, 0, 4'hF, 8'h77, 4'h0, 8'h00};
        vecs[9] = '{"readF",      2, 8'hBB, 8'h2F, 8'h00, 0, 1, 1, 4'h0, 8'h00, 4'hF, 8'h77};

        repeat (3) tick();
        chk("reset_outputs", {Address, WrEn, RdEn, WrData, TX_Data, TX_Valid, Busy, Err}, 32'h0);
        RST = 1'b0;
        tick();
        #1;

        // Table-driven commands.
        for (int i = 0; i < 10; i++) begin
            w0 = wr_cnt; r0 = rd_cnt; t0 = tx_cnt;
            send(vecs[i].b0);
            if (vecs[i].n > 1) send(vecs[i].b1);
            if (vecs[i].n > 2) send(vecs[i].b2);
            repeat (6) tick();
            #1;
            chk({vecs[i].name, "_wr_cnt"}, 32'(wr_cnt - w0), 32'(vecs[i].exp_wr));
            chk({vecs[i].name, "_rd_cnt"}, 32'(rd_cnt - r0), 32'(vecs[i].exp_rd));
            chk({vecs[i].name, "_tx_cnt"}, 32'(tx_cnt - t0), 32'(vecs[i].exp_tx));
            if (vecs[i].exp_wr > 0) begin
                chk({vecs[i].name, "_wr_addr"}, 32'(last_wa), 32'(vecs[i].exp_wa));
                chk({vecs[i].name, "_wr_data"}, 32'(last_wd), 32'(vecs[i].exp_wd));
            end
            if (vecs[i].exp_rd > 0) chk({vecs[i].name, "_rd_addr"}, 32'(last_ra), 32'(vecs[i].exp_ra));
            if (vecs[i].exp_tx > 0) chk({vecs[i].name, "_tx_data"}, 32'(last_tx), 32'(vecs[i].exp_tx_d));
            chk({vecs[i].name, "_busy_end"}, 32'(Busy), 32'd0);
        end

        // Write latency: strobe in the cycle right after the data byte.
        send(8'hAA);
        send(8'h03);
        chk("wr_busy_mid", 32'(Busy), 32'd1);
        chk("wr_no_early", 32'(WrEn), 32'd0);
        send(8'h5A);
        chk("wr_lat_strobe", {WrEn, RdEn, Address, WrData}, {2'b10, 4'h3, 8'h5A});
        tick();
        chk("wr_lat_single", {WrEn, Busy}, 32'd0);

        // Read latency: RdEn next cycle, TX_Valid three cycles after address.
        send(8'hBB);
        send(8'h03);
        chk("rd_lat_strobe", {WrEn, RdEn, Address}, {2'b01, 4'h3});
        tick();
        chk("rd_lat_c2", {RdEn, TX_Valid, Busy}, 32'b001);
        tick();
        chk("rd_lat_tx", {TX_Valid, TX_Data}, {1'b1, 8'h5A});
        tick();
        chk("rd_lat_tx_single", {TX_Valid, Busy}, 32'd0);

        // Backpressure, with a command byte dropped while waiting.
        FIFO_Full = 1'b1;
        t0 = tx_cnt; w0 = wr_cnt;
        send(8'hBB);
        send(8'h05);
        hi_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin RX_Data = 8'hAA; RX_Valid = 1'b1; end
            if (c == 5) begin RX_Data = 8'h00; RX_Valid = 1'b0; end
            tick();
            if (TX_Valid) hi_cnt++;
        end
        chk("bp_held_off", 32'(hi_cnt), 32'd0);
        chk("bp_busy", 32'(Busy), 32'd1);
        FIFO_Full = 1'b0;
        tick();
        chk("bp_release", {TX_Valid, TX_Data}, {1'b1, 8'h3C});
        tick();
        chk("bp_single", 32'(TX_Valid), 32'd0);
        send(8'h07);
        repeat (4) tick();
        chk("drop_busy", 32'(Busy), 32'd0);
        #1;
        chk("bp_tx_cnt", 32'(tx_cnt - t0), 32'd1);
        chk("drop_no_wr", 32'(wr_cnt - w0), 32'd0);

        // Reset mid-command aborts; next byte decoded as a command.
        w0 = wr_cnt;
        send(8'hAA);
        send(8'h02);
        RST = 1'b1;
        #1;
        chk("rst_async", {Busy, Address, WrEn}, 32'd0);
        tick();
        RST = 1'b0;
        tick();
        send(8'h07);
        repeat (4) tick();
        chk("rst_busy", 32'(Busy), 32'd0);
        #1;
        chk("rst_no_wr", 32'(wr_cnt - w0), 32'd0);

        // Read with no response.
        rd_resp_en = 1'b0;
        t0 = tx_cnt; e0 = err_cnt;
        send(8'hBB);
        send(8'h04);
`ifdef RD_TIMEOUT_EN
        hi_cnt = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (Err) hi_cnt++;
        end
        chk("tmo_no_early", 32'(hi_cnt), 32'd0);
        tick();
        chk("tmo_err", {Err, Busy}, 2'b10);
        tick();
        chk("tmo_err_single", 32'(Err), 32'd0);
        #1;
        chk("tmo_no_tx", 32'(tx_cnt - t0), 32'd0);
        chk("tmo_err_cnt", 32'(err_cnt - e0), 32'd1);
`else
        repeat (20) tick();
        chk("wait_busy", 32'(Busy), 32'd1);
        #1;
        chk("wait_no_err", 32'(err_cnt - e0), 32'd0);
        chk("wait_no_tx", 32'(tx_cnt - t0), 32'd0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
`endif
        rd_resp_en = 1'b1;
        tick();
        chk("end_idle", 32'(Busy), 32'd0);
        chk("never_both", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
